onehot_opcode_encoder: RTL and testbench
========================================

// Module: onehot_opcode_encoder
// PURPOSE
//  Reverse path of the 3-to-8 instruction decoder: turns an 8-bit one-hot instruction vector
//  back into a 3-bit opcode. Used by the control-unit trace/debug path to re-pack decoded
//  instruction lines into opcodes. Valid/ready on both sides, an internal 2-entry buffer,
//  per-item not-one-hot error tagging and a saturating error counter.
// PARAMETERS
//  INSTR_W  8  one-hot input width (power of two)
//  OP_W     3  opcode width, = log2(INSTR_W)
//  DEPTH    2  buffer entries (power of two, >=2)
//  CNT_W    8  error counter width
// PORTS
//  clk          in   1        rising-edge clock
//  reset_n      in   1        synchronous reset, active low
//  in_valid     in   1        instruction word offered
//  in_ready     out  1        block can accept (buffer not full)
//  instruction  in   INSTR_W  one-hot instruction vector
//  out_valid    out  1        opcode available at buffer head
//  out_ready    in   1        consumer takes head
//  opcode       out  OP_W     encoded opcode at head
//  out_err      out  1        head entry was not a legal one-hot word
//  err_sticky   out  1        set on any accepted error item, held until err_clr
//  err_count    out  CNT_W    accepted error items, saturates at all-ones
//  err_clr      in   1        clears err_sticky and err_count
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-low on reset_n.
//  - Reset (reset_n=0 at a clk edge): buffer flushed, count=0, out_valid=0, opcode=0,
//    out_err=0, err_sticky=0, err_count=0. in_ready is 1 in the first cycle after reset.
//    A reset in mid-stream drops all buffered entries. No output handshake completes in that cycle.
//  - Accept when in_valid & in_ready. Pop when out_valid & out_ready. Both may happen in one cycle.
//  - in_ready = (count != DEPTH). It is registered-state based and has no combinational path
//    from out_ready. A push while full cannot occur.
//  - Latency: a word accepted at edge N is visible at edge N+1 (out_valid=1) if the buffer was empty.
//  - Order is strictly FIFO. The read and write pointers wrap modulo DEPTH.
//  - Simultaneous push and pop: count is unchanged, and the head advances to the next entry.
//  - opcode/out_err are driven from the head entry. They are held stable while out_valid & !out_ready.
//    They are 0 when the buffer is empty.
//  - Encoding, evaluated at accept time:
//      exactly one bit set, at index k : opcode=k,  err=0
//      zero bits set                   : opcode=0,  err=1
//      two or more bits set            : see CONFIGURATION
//  - Error accounting happens on accept, not on pop. An accepted err=1 item sets err_sticky and
//    increments err_count. At all-ones the counter holds.
//  - err_clr has priority over a same-cycle error increment: the result is 0 and sticky clear.
//  - reset_n has priority over everything.
// CONFIGURATION
//  PRIORITY_RESOLVE_EN defined:
//    multi-hot input -> opcode = index of the highest set bit, err=0, not counted.
//    (e.g. 8'b0010_0100 -> 3'd5)
//  PRIORITY_RESOLVE_EN undefined (default):
//    multi-hot input -> opcode=0, err=1, counted as an error.
// STRUCTURE
//  - Shared package bascomp_pkg:
//      INSTR_W, OP_W
//      opcode localparams OP_0..OP_7
//      typedef enc_entry_t {opcode[OP_W-1:0], err}
//  - Sub-module enc_fifo: DEPTH-entry synchronous buffer of enc_entry_t with count, full
//    and empty. The encode function and error counter stay in the top module.
// TESTING
//  1. Sweep instruction 8'h80,8'h40,...,8'h01 with out_ready=1 -> opcode 7,6,...,0, out_err=0,
//     1-cycle latency, err_count=0.
//  2. out_ready=0, push 8'h04, 8'h10 -> in_ready drops to 0 after the 2nd accept, head holds
//     opcode=2. Raise out_ready -> pops 2 then 4.
//  3. Push 8'h00 -> opcode=0, out_err=1, err_sticky=1, err_count=1.
//     Pulse err_clr -> both return to 0.
//  4. Push 8'h24 -> default build: opcode=0, out_err=1, err_count+1.
//     PRIORITY_RESOLVE_EN build: opcode=5, out_err=0, err_count unchanged.
//  5. Count=1 with in_valid=out_ready=1 held for 10 cycles of one-hot words -> one pop per cycle,
//     count stays 1, order preserved.
//  6. Buffer full (2 entries), drive reset_n=0 for one edge -> out_valid=0, in_ready=1,
//     err_count=0. The next push 8'h02 emerges as opcode=1.
//  Also: 300 consecutive 8'h00 pushes -> err_count saturates at 8'hFF.

Source files
------------

// File: rtl/bascomp_pkg.sv
// Shared widths, opcode constants and the buffered entry type for the opcode re-packing path.
package bascomp_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OP_W    = $clog2(INSTR_W);

  localparam logic [OP_W-1:0] OP_0 = OP_W'(0);
  localparam logic [OP_W-1:0] OP_1 = OP_W'(1);
  localparam logic [OP_W-1:0] OP_2 = OP_W'(2);
  localparam logic [OP_W-1:0] OP_3 = OP_W'(3);
  localparam logic [OP_W-1:0] OP_4 = OP_W'(4);
  localparam logic [OP_W-1:0] OP_5 = OP_W'(5);
  localparam logic [OP_W-1:0] OP_6 = OP_W'(6);
  localparam logic [OP_W-1:0] OP_7 = OP_W'(7);

  typedef struct packed {
    logic [OP_W-1:0] opcode;
    logic            err;
  } enc_entry_t;

endpackage

// File: rtl/enc_fifo.sv
// DEPTH-entry synchronous FIFO of encoded entries; head reads as zero when empty.
module enc_fifo
  import bascomp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  enc_entry_t wdata_i,
  input  logic       pop_i,
  output enc_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  enc_entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop_ok) count_d = count_q + CntW'(1);
    if (!push_ok && pop_ok) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/onehot_opcode_encoder.sv
// One-hot instruction vector to opcode encoder with buffering and error accounting.
// Define PRIORITY_RESOLVE_EN to resolve multi-hot words to their highest set bit.
module onehot_opcode_encoder
  import bascomp_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    opcode,
  output logic               out_err,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   err_count,
  input  logic               err_clr
);

  function automatic enc_entry_t encode(logic [INSTR_W-1:0] instr);
    enc_entry_t      e;
    int unsigned     ones;
    logic [OP_W-1:0] hi;
    ones = 0;
    hi   = '0;
    for (int i = 0; i < INSTR_W; i++) begin
      if (instr[i]) begin
        ones++;
        hi = OP_W'(i);
      end
    end
    e.opcode = OP_0;
    e.err    = 1'b0;
    if (ones == 1) begin
      e.opcode = hi;
    end else if (ones == 0) begin
      e.err = 1'b1;
    end else begin
`ifdef PRIORITY_RESOLVE_EN
      e.opcode = hi;
`else
      e.err = 1'b1;
`endif
    end
    return e;
  endfunction

  enc_entry_t       enc, head;
  logic             full, empty, push, pop;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign enc       = encode(instruction);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign opcode    = head.opcode;
  assign out_err   = head.err;

  enc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push_i (push),
    .wdata_i(enc),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );

  // Errors are counted when accepted; a clear wins over a same-cycle increment.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (err_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (push && enc.err) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_onehot_opcode_encoder.sv
// Randomized and directed bench for onehot_opcode_encoder against a queue-based reference model.
module tb_onehot_opcode_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] instruction;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] opcode;
  logic       out_err;
  logic       err_sticky;
  logic [7:0] err_count;
  logic       err_clr;

  always #5 clk = ~clk;

  onehot_opcode_encoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instruction(instruction),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .opcode     (opcode),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Model state: queued {err, opcode} items, sticky flag and error count.
  logic [3:0]  mdl_q[$];
  logic        mdl_sticky;
  int unsigned mdl_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_enc(input logic [7:0] x);
    int n;
    int hi;
    n  = $countones(x);
    hi = 0;
    while (hi < 7 && (int'(x) >> (hi + 1)) != 0) hi++;
    if (n == 1) return {1'b0, 3'($clog2(x))};
    if (n == 0) return 4'b1000;
`ifdef PRIORITY_RESOLVE_EN
    return {1'b0, 3'(hi)};
`else
    return 4'b1000;
`endif
  endfunction

  // Called just after a falling edge: check outputs, drive inputs, advance model, wait one cycle.
  task automatic cycle(input logic v, input logic [7:0] ins, input logic r, input logic clr,
                       input logic rn);
    logic [3:0] hd;
    logic       acc, pp;
    hd = (mdl_q.size() != 0) ? mdl_q[0] : 4'b0;
    check("out_valid", 32'(out_valid), 32'(mdl_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(mdl_q.size() < 2));
    check("opcode", 32'(opcode), 32'(hd[2:0]));
    check("out_err", 32'(out_err), 32'(hd[3]));
    check("err_sticky", 32'(err_sticky), 32'(mdl_sticky));
    check("err_count", 32'(err_count), mdl_cnt);
    in_valid    = v;
    instruction = ins;
    out_ready   = r;
    err_clr     = clr;
    reset_n     = rn;
    if (!rn) begin
      mdl_q.delete();
      mdl_sticky = 1'b0;
      mdl_cnt    = 0;
    end else begin
      acc = v && (mdl_q.size() < 2);
      pp  = r && (mdl_q.size() != 0);
      if (clr) begin
        mdl_sticky = 1'b0;
        mdl_cnt    = 0;
      end else if (acc && ref_enc(ins)[3]) begin
        mdl_sticky = 1'b1;
        if (mdl_cnt < 255) mdl_cnt++;
      end
      if (pp) void'(mdl_q.pop_front());
      if (acc) mdl_q.push_back(ref_enc(ins));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] w;
    in_valid    = 1'b0;
    instruction = 8'h00;
    out_ready   = 1'b0;
    err_clr     = 1'b0;
    reset_n     = 1'b0;
    mdl_sticky  = 1'b0;
    mdl_cnt     = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // 1: one-hot sweep, streaming
    for (int i = 7; i >= 0; i--) begin
      w = 8'h01 << i;
      cycle(1'b1, w, 1'b1, 1'b0, 1'b1);
    end
    idle(2);

    // 2: stall with two entries, then drain
    cycle(1'b1, 8'h04, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);

    // 3: zero word error, then clear
    cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(1);

    // 4: multi-hot word
    cycle(1'b1, 8'h24, 1'b1, 1'b0, 1'b1);
    idle(2);

    // 4b: clear wins over a same-cycle error accept
    cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(2);

    // 5: steady stream at count 1
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      w = 8'h01 << ((i * 3) % 8);
      cycle(1'b1, w, 1'b1, 1'b0, 1'b1);
    end
    idle(2);

    // 6: reset while full
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Saturation
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(2);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       w = 8'($urandom);
        default: w = 8'h01 << $urandom_range(0, 7);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 80) != 0));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
